// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative read-only cache controller: tree-PLRU replacement, early restart on miss.
// Define CACHE_CTRL_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module cache_ctrl_assoc #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_req_valid,
  output logic          up_req_ready,
  input  logic [AW-1:0] up_req_addr,
  output logic          up_resp_valid,
  output logic [DW-1:0] up_resp_data,
  output logic          dn_req_valid,
  input  logic          dn_req_ready,
  output logic [AW-1:0] dn_req_addr,
  input  logic          dn_resp_valid,
  input  logic [DW-1:0] dn_resp_data,
  input  logic          flush
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]   stat_hits,
  output logic [31:0]   stat_misses
`endif
);

  localparam int BO   = $clog2(DW / 8);
  localparam int WO   = $clog2(LINE_WORDS);
  localparam int IW   = $clog2(SETS);
  localparam int TW   = AW - IW - WO - BO;
  localparam int LVLS = $clog2(WAYS);
  localparam int WAYW = (WAYS > 1) ? LVLS : 1;
  localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOOKUP   = 2'd1;
  localparam logic [1:0] S_MISS_REQ = 2'd2;
  localparam logic [1:0] S_FILL     = 2'd3;

  // Tree nodes use heap order (children of n are 2n+1, 2n+2); a node bit points toward the LRU half.
  function automatic logic [WAYW-1:0] plru_victim(input logic [PW-1:0] bits);
    int node;
    node = 0;
    for (int l = 0; l < LVLS; l++) begin
      node = 2 * node + 1 + int'(bits[node]);
    end
    return WAYW'(node - (WAYS - 1));
  endfunction

  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] bits, input logic [WAYW-1:0] way);
    logic [PW-1:0] res;
    logic          dir;
    int            node;
    res  = bits;
    node = 0;
    for (int l = 0; l < LVLS; l++) begin
      dir       = way[LVLS-1-l];
      res[node] = ~dir;
      node      = 2 * node + 1 + int'(dir);
    end
    return res;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic [WAYW-1:0] victim_q;
  logic [WO-1:0]   beat_q;
  logic            resp_valid_q;
  logic [DW-1:0]   resp_data_q;
  logic            dn_req_valid_q;
  logic [AW-1:0]   dn_req_addr_q;
  logic            flush_pend_q;

  logic [WAYS-1:0] valid_q [SETS];
  logic [PW-1:0]   plru_q  [SETS];
  logic [TW-1:0]   tag_q   [SETS][WAYS];
  logic [DW-1:0]   data_q  [SETS][WAYS][LINE_WORDS];

  logic [WO-1:0]   req_word_s;
  logic [IW-1:0]   req_idx_s;
  logic [TW-1:0]   req_tag_s;
  logic [WAYS-1:0] hit_vec_s;
  logic            hit_s;
  logic [WAYW-1:0] hit_way_s;
  logic [WAYW-1:0] inv_way_s;
  logic [WAYW-1:0] victim_s;
  logic            do_flush_s;
  logic            accept_s;
  logic            beat_s;
  logic            fill_done_s;
  logic            unused_s;

  assign req_word_s = addr_q[BO +: WO];
  assign req_idx_s  = addr_q[BO + WO +: IW];
  assign req_tag_s  = addr_q[AW-1 -: TW];
  assign unused_s   = ^addr_q[BO-1:0];

  // A pending or incoming flush owns the IDLE cycle, so no request is accepted alongside it.
  assign do_flush_s   = (state_q == S_IDLE) && (flush || flush_pend_q);
  assign up_req_ready = (state_q == S_IDLE) && !flush && !flush_pend_q;
  assign accept_s     = up_req_valid && up_req_ready;
  assign beat_s       = (state_q == S_FILL) && dn_resp_valid;
  assign fill_done_s  = beat_s && (beat_q == WO'(LINE_WORDS - 1));

  assign up_resp_valid = resp_valid_q;
  assign up_resp_data  = resp_data_q;
  assign dn_req_valid  = dn_req_valid_q;
  assign dn_req_addr   = dn_req_addr_q;

  // Tag match across the set; victim is the lowest invalid way, else the PLRU choice.
  always_comb begin
    hit_vec_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w] = valid_q[req_idx_s][w] && (tag_q[req_idx_s][w] == req_tag_s);
    end
    hit_s     = |hit_vec_s;
    hit_way_s = '0;
    inv_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_way_s = hit_vec_s[w] ? WAYW'(w) : hit_way_s;
      inv_way_s = valid_q[req_idx_s][w] ? inv_way_s : WAYW'(w);
    end
    victim_s = (&valid_q[req_idx_s]) ? plru_victim(plru_q[req_idx_s]) : inv_way_s;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = accept_s ? S_LOOKUP : S_IDLE;
      S_LOOKUP:   state_d = hit_s ? S_IDLE : S_MISS_REQ;
      S_MISS_REQ: state_d = dn_req_ready ? S_FILL : S_MISS_REQ;
      S_FILL:     state_d = fill_done_s ? S_IDLE : S_FILL;
      default:    state_d = S_IDLE;
    endcase
  end

  // Control registers and registered response/request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      victim_q       <= '0;
      beat_q         <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      dn_req_valid_q <= 1'b0;
      dn_req_addr_q  <= '0;
      flush_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= 1'b0;
      if (do_flush_s) begin
        flush_pend_q <= 1'b0;
      end else if (flush) begin
        flush_pend_q <= 1'b1;
      end
      if (accept_s) begin
        addr_q <= up_req_addr;
      end
      case (state_q)
        S_LOOKUP: begin
          beat_q <= '0;
          if (hit_s) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= data_q[req_idx_s][hit_way_s][req_word_s];
          end else begin
            victim_q       <= victim_s;
            dn_req_valid_q <= 1'b1;
            dn_req_addr_q  <= {req_tag_s, req_idx_s, {(WO + BO){1'b0}}};
          end
        end
        S_MISS_REQ: begin
          if (dn_req_ready) begin
            dn_req_valid_q <= 1'b0;
          end
        end
        S_FILL: begin
          if (dn_resp_valid) begin
            beat_q <= beat_q + WO'(1);
            if (beat_q == req_word_s) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= dn_resp_data;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Valid and PLRU state; flush and reset both clear the whole array in one cycle.
  always_ff @(posedge clk) begin
    if (rst || do_flush_s) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if ((state_q == S_LOOKUP) && hit_s) begin
        plru_q[req_idx_s] <= plru_touch(plru_q[req_idx_s], hit_way_s);
      end
      if (fill_done_s) begin
        valid_q[req_idx_s][victim_q] <= 1'b1;
        plru_q[req_idx_s]            <= plru_touch(plru_q[req_idx_s], victim_q);
      end
    end
  end

  // Tag and data storage, qualified by the valid bits so no reset is needed.
  always_ff @(posedge clk) begin
    if (beat_s) begin
      data_q[req_idx_s][victim_q][beat_q] <= dn_resp_data;
    end
    if (fill_done_s) begin
      tag_q[req_idx_s][victim_q] <= req_tag_s;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] stat_hits_q;
  logic [31:0] stat_misses_q;

  // Saturating hit/miss counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits_q   <= 32'd0;
      stat_misses_q <= 32'd0;
    end else if (state_q == S_LOOKUP) begin
      if (hit_s) begin
        if (stat_hits_q != 32'hFFFF_FFFF) begin
          stat_hits_q <= stat_hits_q + 32'd1;
        end
      end else begin
        if (stat_misses_q != 32'hFFFF_FFFF) begin
          stat_misses_q <= stat_misses_q + 32'd1;
        end
      end
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Scoreboard bench for cache_ctrl_assoc (default parameters, 2-way, 16 sets, 4-word lines).
module tb_cache_ctrl_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_req_valid;
  logic        up_req_ready;
  logic [31:0] up_req_addr;
  logic        up_resp_valid;
  logic [31:0] up_resp_data;
  logic        dn_req_valid;
  logic        dn_req_ready;
  logic [31:0] dn_req_addr;
  logic        dn_resp_valid;
  logic [31:0] dn_resp_data;
  logic        flush;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb [$];

  cache_ctrl_assoc dut (
    .clk           (clk),
    .rst           (rst),
    .up_req_valid  (up_req_valid),
    .up_req_ready  (up_req_ready),
    .up_req_addr   (up_req_addr),
    .up_resp_valid (up_resp_valid),
    .up_resp_data  (up_resp_data),
    .dn_req_valid  (dn_req_valid),
    .dn_req_ready  (dn_req_ready),
    .dn_req_addr   (dn_req_addr),
    .dn_resp_valid (dn_resp_valid),
    .dn_resp_data  (dn_resp_data),
    .flush         (flush)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Backing memory: fixed beats for line 0x1F0, a hash of address and beat elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
    logic [31:0] tbl [4];
    tbl = '{32'hFF0000FF, 32'hF0F0F0F0, 32'h00FFFF00, 32'h00FF00FF};
    if (line == 32'h0000_01F0) return tbl[i];
    return (line * 32'h9E37_79B1) ^ (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  always @(negedge clk) begin
    if (up_resp_valid) begin
      if (sb.size() == 0) chk("spurious_resp", 64'd1, 64'd0);
      else chk("resp_data", up_resp_data, sb.pop_front());
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, up_req_ready, 1'b1);
    chk({tag, "_resp_valid"}, up_resp_valid, 1'b0);
    chk({tag, "_resp_data"}, up_resp_data, 32'd0);
    chk({tag, "_dn_valid"}, dn_req_valid, 1'b0);
    chk({tag, "_dn_addr"}, dn_req_addr, 32'd0);
`ifdef CACHE_CTRL_STATS_EN
    chk({tag, "_stat_hits"}, stat_hits, 32'd0);
    chk({tag, "_stat_misses"}, stat_misses, 32'd0);
`endif
  endtask

  // One read transaction; called and returning at a falling edge.
  task automatic do_read(input logic [31:0] addr, input bit exp_hit, input int bp, input int gap,
                         input int flush_beat, input bit flush_req, input int rst_after);
    logic [31:0] line;
    int          word;
    int          n;
    line = addr & ~32'hF;
    word = int'(addr[3:2]);
    n = 0;
    while (!up_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'd0, 64'd1);
    if (flush_req) begin
      flush = 1'b1; up_req_valid = 1'b1; up_req_addr = addr;
      #1;
      chk("flush_blocks_req", up_req_ready, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("ready_after_flush", up_req_ready, 1'b1);
    end
    up_req_valid = 1'b1; up_req_addr = addr;
    sb.push_back(mem_word(line, word));
    @(negedge clk);
    up_req_valid = 1'b0;
    chk("lookup_no_resp", up_resp_valid, 1'b0);
    chk("lookup_busy", up_req_ready, 1'b0);
    @(negedge clk);
    if (exp_hit) begin
      chk("hit_resp_t2", up_resp_valid, 1'b1);
      chk("hit_no_dn", dn_req_valid, 1'b0);
      return;
    end
    chk("miss_dn_valid", dn_req_valid, 1'b1);
    chk("miss_dn_addr", dn_req_addr, line);
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      chk("bp_hold", {dn_req_valid, dn_req_addr}, {1'b1, line});
    end
    dn_req_ready = 1'b1;
    @(negedge clk);
    dn_req_ready = 1'b0;
    chk("dn_req_drop", dn_req_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == rst_after) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("mid_fill_rst");
        sb.delete();
        for (int j = i; j < 4; j++) begin
          dn_resp_valid = 1'b1; dn_resp_data = mem_word(line, j);
          @(negedge clk);
          dn_resp_valid = 1'b0;
          chk("stale_beat_ignored", up_resp_valid, 1'b0);
        end
        return;
      end
      for (int g = 0; g < gap; g++) @(negedge clk);
      dn_resp_valid = 1'b1; dn_resp_data = mem_word(line, i);
      flush = (i == flush_beat);
      @(negedge clk);
      dn_resp_valid = 1'b0; flush = 1'b0;
      chk("early_restart", up_resp_valid, (i == word));
      if (i < 3) chk("fill_busy", up_req_ready, 1'b0);
    end
    chk("fill_done_ready", up_req_ready, (flush_beat < 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; up_req_valid = 1'b0; up_req_addr = 32'd0; dn_req_ready = 1'b0;
    dn_resp_valid = 1'b0; dn_resp_data = 32'd0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // cold miss then hit
    do_read(32'h0000_01F0, 1'b0, 0, 0, -1, 1'b0, -1);
    do_read(32'h0000_01F8, 1'b1, 0, 0, -1, 1'b0, -1);
    // critical word last, then a stray beat in IDLE
    do_read(32'h0440_01FC, 1'b0, 0, 0, -1, 1'b0, -1);
    dn_resp_valid = 1'b1; dn_resp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    dn_resp_valid = 1'b0;
    chk("stray_beat_no_resp", up_resp_valid, 1'b0);
    chk("stray_beat_ready", up_req_ready, 1'b1);
    do_read(32'h0440_01F4, 1'b1, 0, 0, -1, 1'b0, -1);
    // PLRU eviction in set 0xF
    do_read(32'h0110_01F0, 1'b0, 0, 0, -1, 1'b0, -1);
    do_read(32'h0220_01F0, 1'b0, 0, 0, -1, 1'b0, -1);
    do_read(32'h0110_01F0, 1'b1, 0, 0, -1, 1'b0, -1);
    do_read(32'h0330_01F0, 1'b0, 0, 0, -1, 1'b0, -1);
    do_read(32'h0110_01F0, 1'b1, 0, 0, -1, 1'b0, -1);
    do_read(32'h0220_01F0, 1'b0, 0, 0, -1, 1'b0, -1);
    // downstream backpressure and gapped beats
    do_read(32'h0770_00A4, 1'b0, 5, 3, -1, 1'b0, -1);
    do_read(32'h0770_00AC, 1'b1, 0, 0, -1, 1'b0, -1);
    // flush during fill, then the filled line is gone
    do_read(32'h0550_00B4, 1'b0, 0, 0, 1, 1'b0, -1);
    do_read(32'h0550_00B4, 1'b0, 0, 0, -1, 1'b0, -1);
    do_read(32'h0770_00A4, 1'b0, 0, 0, -1, 1'b0, -1);
    // flush alongside a request in IDLE
    do_read(32'h0550_00B8, 1'b0, 0, 0, -1, 1'b1, -1);
    // reset mid-fill after two beats
    do_read(32'h0660_01FC, 1'b0, 0, 0, -1, 1'b0, 2);
    do_read(32'h0660_01FC, 1'b0, 0, 0, -1, 1'b0, -1);
    do_read(32'h0660_01F0, 1'b1, 0, 0, -1, 1'b0, -1);
`ifdef CACHE_CTRL_STATS_EN
    chk("stat_hits_end", stat_hits, 32'd1);
    chk("stat_misses_end", stat_misses, 32'd1);
`endif
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
